regfile_port_ctrl: RTL and testbench
====================================

Name: regfile_port_ctrl

Overview:
- Control and bypass stage wrapped around the two simple-dual-port BRAM register-file banks (rs1 bank, rs2 bank) of the barrel RISC-V core.
- Upstream side: drives both banks' write ports from writeback, and their read ports from decode. Downstream side: consumes both banks' registered read data.
- Adds the following on top of the raw banks: a power-up/reset clear sequencer, x0 hard-wiring, and same-cycle read/write collision forwarding. The banks themselves provide no collision guarantee.
- Register address = {thread_id, reg_idx}.

Parameters:
- NUM_THREADS, 16, number of hardware threads (power of 2).
- THREAD_W, 4, log2(NUM_THREADS).
- ADDR_WIDTH, THREAD_W+5, bank address width.
- SIZE, NUM_THREADS*32, bank depth.
- DATA_WIDTH, 32, register width.

Ports:
- clk  in  1  core clock; both banks share it.
- reset  in  1  synchronous, active-high reset.
- rd_en  in  1  read request (decode stage).
- rd_tid  in  THREAD_W  thread of read.
- rs1_idx  in  5  source register 1.
- rs2_idx  in  5  source register 2.
- wb_en  in  1  writeback request.
- wb_tid  in  THREAD_W  thread of writeback.
- wb_rd  in  5  destination register.
- wb_data  in  DATA_WIDTH  writeback value.
- busy  out  1  clear sequence in progress; reads and writebacks are dropped.
- rs_valid  out  1  rs1_data/rs2_data valid this cycle.
- rs1_data  out  DATA_WIDTH  operand 1.
- rs2_data  out  DATA_WIDTH  operand 2.
- bram_ena  out  1  bank write enable (drives ena and wea of both banks).
- bram_waddr  out  ADDR_WIDTH  bank write address.
- bram_wdata  out  DATA_WIDTH  bank write data.
- bram_enb  out  1  bank read enable (both banks).
- bram_raddr1  out  ADDR_WIDTH  rs1 bank read address.
- bram_raddr2  out  ADDR_WIDTH  rs2 bank read address.
- bram_dob1  in  DATA_WIDTH  rs1 bank read data (1-cycle latency).
- bram_dob2  in  DATA_WIDTH  rs2 bank read data.

Behaviour:

FSM states: CLEAR, RUN.
- reset=1 → state CLEAR, clr_cnt=0, rs_valid=0, both operand selects forced to "zero", so rs1_data=rs2_data=0.
- Reset asserted mid-operation restarts the clear from address 0.

CLEAR state:
- busy=1, bram_ena=1, bram_waddr=clr_cnt, bram_wdata=0, bram_enb=0.
- clr_cnt increments each cycle.
- When clr_cnt=SIZE-1 the write still happens and the next state is RUN.
- Duration is exactly SIZE cycles after reset deasserts.
- rd_en and wb_en are ignored. Requests are not queued; the pipeline is required to stall on busy.

RUN state, busy=0. Write path is combinational pass-through, same cycle:
- bram_ena = wb_en & (wb_rd≠0).
- bram_waddr = {wb_tid, wb_rd}.
- bram_wdata = wb_data.
- Writes to x0 are suppressed.

RUN state, read path:
- bram_enb = rd_en.
- bram_raddrN = {rd_tid, rsN_idx}.
- For each port N, at the cycle of an accepted read, register one select:
  - ZERO if rsN_idx=0;
  - else FWD if bram_ena and bram_waddr = {rd_tid, rsN_idx}; also capture wb_data into fwd_dataN;
  - else BRAM.
- Next cycle: rs_valid=1, and rsN_data = 0 / fwd_dataN / bram_dobN according to the select.
- Latency: exactly 1 cycle from rd_en to rs_valid.
- A write landing one or more cycles before the read needs no forwarding; the bank already holds the value.
- If there is no read in a cycle: rs_valid=0 next cycle, and rsN_data hold their last value (selects, fwd_data and bank outputs all hold).
- Back-to-back reads every cycle are supported, at full throughput.
- rs1_idx=rs2_idx is legal; both ports return identical data.
- A writeback and a read to a different thread in the same cycle do not interact.

Test Plan:
- Reset for 2 cycles, then release → busy=1 for exactly 512 cycles. bram_ena=1 with bram_waddr sweeping 0..511 and bram_wdata=0. busy=0 on cycle 513; rs_valid stays 0 throughout.
- After clear: wb tid=3 rd=5 data=0xDEADBEEF. Two cycles later, read tid=3 rs1=5 rs2=0 → next cycle rs_valid=1, rs1_data=0xDEADBEEF, rs2_data=0.
- Same-cycle collision: wb tid=7 rd=10 data=0x12345678 together with read tid=7 rs1=10 rs2=10 → next cycle both outputs 0x12345678, regardless of bram_dob.
- wb tid=0 rd=0 data=0xFFFFFFFF → bram_ena=0. A subsequent read of rs1=0 returns 0.
- Reset asserted at clear address 200 → clr_cnt restarts at 0, and busy lasts a further full 512 cycles. A read issued while busy is dropped: no rs_valid.
- 16 back-to-back reads of tids 0..15, each tid holding data=tid → rs_valid high for 16 consecutive cycles, outputs 0..15 in order. After the stream ends, outputs hold 15.

Source files
------------

// File: rtl/regfile_port_ctrl.sv
// rtl/regfile_port_ctrl.sv - register-file bank control: reset clear, x0 hard-wiring, collision forwarding
module regfile_port_ctrl #(
    parameter int NUM_THREADS = 16,
    parameter int THREAD_W    = 4,
    parameter int ADDR_WIDTH  = THREAD_W + 5,
    parameter int SIZE        = NUM_THREADS * 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic [THREAD_W-1:0]   rd_tid,
    input  logic [4:0]            rs1_idx,
    input  logic [4:0]            rs2_idx,
    input  logic                  wb_en,
    input  logic [THREAD_W-1:0]   wb_tid,
    input  logic [4:0]            wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  busy,
    output logic                  rs_valid,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    output logic                  bram_ena,
    output logic [ADDR_WIDTH-1:0] bram_waddr,
    output logic [DATA_WIDTH-1:0] bram_wdata,
    output logic                  bram_enb,
    output logic [ADDR_WIDTH-1:0] bram_raddr1,
    output logic [ADDR_WIDTH-1:0] bram_raddr2,
    input  logic [DATA_WIDTH-1:0] bram_dob1,
    input  logic [DATA_WIDTH-1:0] bram_dob2
);

    typedef enum logic {CLEAR, RUN} state_t;
    typedef enum logic [1:0] {SEL_ZERO, SEL_FWD, SEL_BRAM} sel_t;

    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(SIZE - 1);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    sel_t                  sel1, sel2, sel1_next, sel2_next;
    logic [DATA_WIDTH-1:0] fwd_data1, fwd_data2;
    logic                  rd_accept;
    logic [ADDR_WIDTH-1:0] rd_addr1, rd_addr2;

    assign rd_addr1    = {rd_tid, rs1_idx};
    assign rd_addr2    = {rd_tid, rs2_idx};
    assign bram_raddr1 = rd_addr1;
    assign bram_raddr2 = rd_addr2;

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        bram_ena   = 1'b0;
        bram_waddr = '0;
        bram_wdata = '0;
        bram_enb   = 1'b0;
        rd_accept  = 1'b0;
        case (state)
            CLEAR: begin
                busy       = 1'b1;
                bram_ena   = 1'b1;
                bram_waddr = clr_cnt;
                if (clr_cnt == CLR_LAST)
                    state_next = RUN;
            end
            RUN: begin
                bram_ena   = wb_en && (wb_rd != 5'd0);
                bram_waddr = {wb_tid, wb_rd};
                bram_wdata = wb_data;
                bram_enb   = rd_en;
                rd_accept  = rd_en;
            end
            default: state_next = CLEAR;
        endcase
    end

    // The banks give no read/write collision guarantee, so a same-cycle write is bypassed here.
    always_comb begin
        sel1_next = SEL_BRAM;
        sel2_next = SEL_BRAM;
        if (rs1_idx == 5'd0)
            sel1_next = SEL_ZERO;
        else if (bram_ena && (bram_waddr == rd_addr1))
            sel1_next = SEL_FWD;
        if (rs2_idx == 5'd0)
            sel2_next = SEL_ZERO;
        else if (bram_ena && (bram_waddr == rd_addr2))
            sel2_next = SEL_FWD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            rs_valid  <= 1'b0;
            sel1      <= SEL_ZERO;
            sel2      <= SEL_ZERO;
            fwd_data1 <= '0;
            fwd_data2 <= '0;
        end else begin
            state    <= state_next;
            rs_valid <= rd_accept;
            if (state == CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
            if (rd_accept) begin
                sel1 <= sel1_next;
                sel2 <= sel2_next;
                if (sel1_next == SEL_FWD)
                    fwd_data1 <= wb_data;
                if (sel2_next == SEL_FWD)
                    fwd_data2 <= wb_data;
            end
        end
    end

    always_comb begin
        case (sel1)
            SEL_FWD:  rs1_data = fwd_data1;
            SEL_BRAM: rs1_data = bram_dob1;
            default:  rs1_data = '0;
        endcase
        case (sel2)
            SEL_FWD:  rs2_data = fwd_data2;
            SEL_BRAM: rs2_data = bram_dob2;
            default:  rs2_data = '0;
        endcase
    end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// tb/tb_regfile_port_ctrl.sv - directed self-checking bench for regfile_port_ctrl
module tb_regfile_port_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_tid = '0;
    logic [4:0]  rs1_idx = '0;
    logic [4:0]  rs2_idx = '0;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_tid = '0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        busy, rs_valid, bram_ena, bram_enb;
    logic [31:0] rs1_data, rs2_data, bram_wdata, bram_dob1, bram_dob2;
    logic [8:0]  bram_waddr, bram_raddr1, bram_raddr2;

    int total = 0;
    int bad = 0;

    logic [31:0] mem1 [0:511];
    logic [31:0] mem2 [0:511];

    regfile_port_ctrl dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_tid(rd_tid),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .wb_en(wb_en), .wb_tid(wb_tid),
        .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy), .rs_valid(rs_valid),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .bram_ena(bram_ena),
        .bram_waddr(bram_waddr), .bram_wdata(bram_wdata), .bram_enb(bram_enb),
        .bram_raddr1(bram_raddr1), .bram_raddr2(bram_raddr2),
        .bram_dob1(bram_dob1), .bram_dob2(bram_dob2)
    );

    always #5 clk = ~clk;

    // Read-first bank model: a same-cycle read returns the old contents.
    always @(posedge clk) begin
        if (bram_ena) begin
            mem1[bram_waddr] <= bram_wdata;
            mem2[bram_waddr] <= bram_wdata;
        end
        if (bram_enb) begin
            bram_dob1 <= mem1[bram_raddr1];
            bram_dob2 <= mem2[bram_raddr2];
        end
    end

    task automatic test_clear_sweep(input bit reads_during);
        rd_en = reads_during; wb_en = reads_during;
        rd_tid = 4'd1; rs1_idx = 5'd1; rs2_idx = 5'd2;
        wb_tid = 4'd1; wb_rd = 5'd1; wb_data = 32'hAAAA5555;
        for (int i = 0; i < 512; i++) begin
            #1;
            total++;
            if (busy !== 1'b1 || bram_ena !== 1'b1 || bram_enb !== 1'b0) begin
                bad++;
                $display("FAIL clr_ctrl i=%0d busy=%b ena=%b enb=%b want 1 1 0", i, busy, bram_ena, bram_enb);
            end
            total++;
            if (bram_waddr !== 9'(i) || bram_wdata !== 32'd0) begin
                bad++;
                $display("FAIL clr_addr i=%0d waddr=%0d wdata=%h want %0d 0", i, bram_waddr, bram_wdata, i);
            end
            total++;
            if (rs_valid !== 1'b0) begin
                bad++;
                $display("FAIL clr_valid i=%0d rs_valid=%b want 0", i, rs_valid);
            end
            @(negedge clk);
        end
        total++;
        if (busy !== 1'b0 || rs_valid !== 1'b0) begin
            bad++;
            $display("FAIL clr_done busy=%b rs_valid=%b want 0 0", busy, rs_valid);
        end
        rd_en = 1'b0; wb_en = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b1 || rs_valid !== 1'b0 || rs1_data !== 32'd0 || rs2_data !== 32'd0 || bram_waddr !== 9'd0) begin
            bad++;
            $display("FAIL reset_state busy=%b valid=%b rs1=%h rs2=%h waddr=%0d want 1 0 0 0 0",
                     busy, rs_valid, rs1_data, rs2_data, bram_waddr);
        end
        reset = 1'b0;
        test_clear_sweep(1'b0);
    endtask

    task automatic test_write_read;
        @(negedge clk);
        wb_en = 1'b1; wb_tid = 4'd3; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        #1;
        total++;
        if (bram_ena !== 1'b1 || bram_waddr !== 9'd101 || bram_wdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL wb_pass ena=%b waddr=%0d wdata=%h want 1 101 deadbeef", bram_ena, bram_waddr, bram_wdata);
        end
        @(negedge clk); wb_en = 1'b0;
        @(negedge clk);
        rd_en = 1'b1; rd_tid = 4'd3; rs1_idx = 5'd5; rs2_idx = 5'd0;
        #1;
        total++;
        if (bram_enb !== 1'b1 || bram_raddr1 !== 9'd101 || bram_raddr2 !== 9'd96) begin
            bad++;
            $display("FAIL rd_addr enb=%b ra1=%0d ra2=%0d want 1 101 96", bram_enb, bram_raddr1, bram_raddr2);
        end
        @(negedge clk); rd_en = 1'b0;
        total++;
        if (rs_valid !== 1'b1 || rs1_data !== 32'hDEADBEEF || rs2_data !== 32'd0) begin
            bad++;
            $display("FAIL rd_data valid=%b rs1=%h rs2=%h want 1 deadbeef 0", rs_valid, rs1_data, rs2_data);
        end
        @(negedge clk);
        total++;
        if (rs_valid !== 1'b0 || rs1_data !== 32'hDEADBEEF || rs2_data !== 32'd0) begin
            bad++;
            $display("FAIL rd_hold valid=%b rs1=%h rs2=%h want 0 deadbeef 0", rs_valid, rs1_data, rs2_data);
        end
    endtask

    task automatic test_collision;
        @(negedge clk);
        wb_en = 1'b1; wb_tid = 4'd7; wb_rd = 5'd10; wb_data = 32'h11111111;
        @(negedge clk); wb_en = 1'b0;
        @(negedge clk);
        wb_en = 1'b1; wb_tid = 4'd7; wb_rd = 5'd10; wb_data = 32'h12345678;
        rd_en = 1'b1; rd_tid = 4'd7; rs1_idx = 5'd10; rs2_idx = 5'd10;
        @(negedge clk); wb_en = 1'b0; rd_en = 1'b0;
        total++;
        if (rs_valid !== 1'b1 || rs1_data !== 32'h12345678 || rs2_data !== 32'h12345678) begin
            bad++;
            $display("FAIL collide valid=%b rs1=%h rs2=%h want 1 12345678 12345678", rs_valid, rs1_data, rs2_data);
        end
        // Writeback to another thread must not be forwarded.
        @(negedge clk);
        wb_en = 1'b1; wb_tid = 4'd8; wb_rd = 5'd10; wb_data = 32'hCAFEF00D;
        rd_en = 1'b1; rd_tid = 4'd7; rs1_idx = 5'd10; rs2_idx = 5'd10;
        @(negedge clk); wb_en = 1'b0; rd_en = 1'b0;
        total++;
        if (rs_valid !== 1'b1 || rs1_data !== 32'h12345678 || rs2_data !== 32'h12345678) begin
            bad++;
            $display("FAIL other_tid valid=%b rs1=%h rs2=%h want 1 12345678 12345678", rs_valid, rs1_data, rs2_data);
        end
    endtask

    task automatic test_x0;
        @(negedge clk);
        wb_en = 1'b1; wb_tid = 4'd0; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
        rd_en = 1'b1; rd_tid = 4'd0; rs1_idx = 5'd0; rs2_idx = 5'd0;
        #1;
        total++;
        if (bram_ena !== 1'b0) begin
            bad++;
            $display("FAIL x0_ena ena=%b want 0", bram_ena);
        end
        @(negedge clk); wb_en = 1'b0;
        total++;
        if (rs_valid !== 1'b1 || rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
            bad++;
            $display("FAIL x0_same valid=%b rs1=%h rs2=%h want 1 0 0", rs_valid, rs1_data, rs2_data);
        end
        @(negedge clk); rd_en = 1'b0;
        total++;
        if (rs_valid !== 1'b1 || rs1_data !== 32'd0) begin
            bad++;
            $display("FAIL x0_read valid=%b rs1=%h want 1 0", rs_valid, rs1_data);
        end
    endtask

    task automatic test_back_to_back;
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            wb_en = 1'b1; wb_tid = 4'(t); wb_rd = 5'd1; wb_data = 32'(t);
        end
        @(negedge clk);
        wb_en = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                total++;
                if (rs_valid !== 1'b1 || rs1_data !== 32'(i - 1) || rs2_data !== 32'(i - 1)) begin
                    bad++;
                    $display("FAIL b2b i=%0d valid=%b rs1=%h rs2=%h want 1 %0d", i, rs_valid, rs1_data, rs2_data, i - 1);
                end
            end
            rd_en = (i < 16); rd_tid = 4'(i); rs1_idx = 5'd1; rs2_idx = 5'd1;
            @(negedge clk);
        end
        total++;
        if (rs_valid !== 1'b0 || rs1_data !== 32'd15 || rs2_data !== 32'd15) begin
            bad++;
            $display("FAIL b2b_hold valid=%b rs1=%h rs2=%h want 0 15 15", rs_valid, rs1_data, rs2_data);
        end
    endtask

    task automatic test_reset_restart;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        total++;
        if (bram_waddr !== 9'd200 || busy !== 1'b1) begin
            bad++;
            $display("FAIL restart_pre waddr=%0d busy=%b want 200 1", bram_waddr, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (bram_waddr !== 9'd0 || busy !== 1'b1 || rs_valid !== 1'b0) begin
            bad++;
            $display("FAIL restart_rst waddr=%0d busy=%b valid=%b want 0 1 0", bram_waddr, busy, rs_valid);
        end
        reset = 1'b0;
        test_clear_sweep(1'b1);
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_collision;
        test_x0;
        test_back_to_back;
        test_reset_restart;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
